// File: rtl/counter_seq_ctrl_if.sv
// Handshake/status bundle between test/control logic (master) and the
// counter sequencer (slave).
interface counter_seq_ctrl_if #(
    parameter int CW = 4
);
    logic          start_i;
    logic [CW-1:0] len_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          cnt_clr_o;
    logic          cnt_inc_o;
    logic [CW-1:0] cnt_o;
    logic [2:0]    state_o;

    modport master (
        output start_i, len_i, abort_i,
        input  busy_o, done_o, cnt_clr_o, cnt_inc_o, cnt_o, state_o
    );

    modport slave (
        input  start_i, len_i, abort_i,
        output busy_o, done_o, cnt_clr_o, cnt_inc_o, cnt_o, state_o
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Counter sequencer: clear -> settle -> count-N -> done, owning the counter.
// Optional macro SEQ_ASSERT_EN compiles in concurrent protocol assertions.
module counter_seq_ctrl #(
    parameter int CW         = 4,
    parameter int HOLD_CYC   = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    counter_seq_ctrl_if.slave   bus
);
    localparam int TW = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_COUNT  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   len_q, len_d;
    logic            busy_q, done_q, clr_q, inc_q;

    // Next-state, counter and timer logic; abort overrides everything else.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    len_d   = bus.len_i;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d = '0;
                if (timer_q == TW'(HOLD_CYC - 1)) begin
                    if (SETTLE_CYC != 0)
                        state_d = ST_SETTLE;
                    else if (len_q == '0)
                        state_d = ST_DONE;
                    else
                        state_d = ST_COUNT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_SETTLE: begin
                cnt_d = '0;
                if (timer_q == TW'(SETTLE_CYC - 1)) begin
                    state_d = (len_q == '0) ? ST_DONE : ST_COUNT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_COUNT: begin
                // The edge that brings cnt up to len_q also leaves COUNT.
                cnt_d = cnt_q + CW'(1);
                if ((cnt_q + CW'(1)) == len_q)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            timer_d = '0;
        end
    end

    // State, counter and registered output decodes (aligned with state_o).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            clr_q   <= (state_d == ST_CLEAR);
            inc_q   <= (state_d == ST_COUNT);
        end
    end

    assign bus.state_o   = state_q;
    assign bus.cnt_o     = cnt_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.cnt_clr_o = clr_q;
    assign bus.cnt_inc_o = inc_q;

`ifdef SEQ_ASSERT_EN
    a_settle_zero: assert property (@(posedge clk) disable iff (rst || bus.abort_i)
        (state_q == ST_SETTLE) |-> (cnt_q == '0))
        else $error("cnt_o nonzero during SETTLE");

    a_count_first_zero: assert property (@(posedge clk) disable iff (rst || bus.abort_i)
        ((state_q == ST_COUNT) && ($past(state_q) != ST_COUNT)) |-> (cnt_q == '0))
        else $error("cnt_o nonzero on first COUNT cycle");

    a_done_single: assert property (@(posedge clk) disable iff (rst || bus.abort_i)
        done_q |=> !done_q)
        else $error("done_o high for two consecutive cycles");

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst || bus.abort_i)
        busy_q |-> (cnt_q <= len_q))
        else $error("cnt_o exceeds len_q while busy");

    a_clr_inc_excl: assert property (@(posedge clk) disable iff (rst || bus.abort_i)
        !(clr_q && inc_q))
        else $error("cnt_clr_o and cnt_inc_o high together");

    a_start_clear: assert property (@(posedge clk) disable iff (rst || bus.abort_i)
        (bus.start_i && (state_q == ST_IDLE)) |=> clr_q)
        else $error("accepted start not followed by cnt_clr_o");
`endif
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed testbench for counter_seq_ctrl (CW=4, HOLD_CYC=1, SETTLE_CYC=2).
module tb_counter_seq_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.CW(CW)) bus ();

    counter_seq_ctrl #(.CW(CW), .HOLD_CYC(1), .SETTLE_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Observed outputs packed as {state, busy, done, clr, inc, cnt}.
    function automatic logic [10:0] obs();
        return {bus.state_o, bus.busy_o, bus.done_o, bus.cnt_clr_o, bus.cnt_inc_o, bus.cnt_o};
    endfunction

    function automatic logic [10:0] exp_vec(input int st, input int cnt);
        logic [2:0] s;
        logic [3:0] c;
        s = 3'(st);
        c = 4'(cnt);
        return {s, (st != 0), (st == 4), (st == 1), (st == 3), c};
    endfunction

    // Expected outputs in cycle c after a start with length n (defaults).
    function automatic logic [10:0] model(input int c, input int n);
        int st;
        int cnt;
        if (c == 1)           st = 1;
        else if (c <= 3)      st = 2;
        else if (c <= 3 + n)  st = 3;
        else if (c == 4 + n)  st = 4;
        else                  st = 0;
        cnt = (c <= 4) ? 0 : ((c - 4 < n) ? c - 4 : n);
        return exp_vec(st, cnt);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Caller is at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic kick(input int n);
        bus.start_i = 1'b1;
        bus.len_i   = 4'(n);
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.start_i = 1'($urandom_range(0, 1));
            bus.len_i   = 4'($urandom_range(0, 15));
            bus.abort_i = 1'($urandom_range(0, 1));
            step();
            if (obs() !== exp_vec(0, 0)) begin
                failures++;
                $display("FAIL reset cyc%0d got=%h exp=%h", i, obs(), exp_vec(0, 0));
            end
            checks++;
        end
        bus.start_i = 1'b0;
        bus.len_i   = '0;
        bus.abort_i = 1'b0;
        rst = 1'b0;
        step();
        if (obs() !== exp_vec(0, 0)) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs(), exp_vec(0, 0));
        end
        checks++;
    endtask

    task automatic test_len5();
        kick(5);
        for (int c = 1; c <= 11; c++) begin
            if (obs() !== model(c, 5)) begin
                failures++;
                $display("FAIL len5 c%0d got=%h exp=%h", c, obs(), model(c, 5));
            end
            checks++;
            step();
        end
    endtask

    task automatic test_len0();
        kick(0);
        for (int c = 1; c <= 6; c++) begin
            if (obs() !== model(c, 0)) begin
                failures++;
                $display("FAIL len0 c%0d got=%h exp=%h", c, obs(), model(c, 0));
            end
            checks++;
            step();
        end
    endtask

    task automatic test_abort();
        kick(5);
        for (int c = 1; c <= 6; c++) begin
            if (obs() !== model(c, 5)) begin
                failures++;
                $display("FAIL abort_pre c%0d got=%h exp=%h", c, obs(), model(c, 5));
            end
            checks++;
            if (c == 6) begin
                bus.abort_i = 1'b1;
                bus.start_i = 1'b1;
            end
            step();
        end
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        for (int c = 7; c <= 8; c++) begin
            if (obs() !== exp_vec(0, 0)) begin
                failures++;
                $display("FAIL abort_idle c%0d got=%h exp=%h", c, obs(), exp_vec(0, 0));
            end
            checks++;
            if (c < 8) step();
        end
        kick(2);
        for (int c = 1; c <= 8; c++) begin
            if (obs() !== model(c, 2)) begin
                failures++;
                $display("FAIL abort_restart c%0d got=%h exp=%h", c, obs(), model(c, 2));
            end
            checks++;
            step();
        end
    endtask

    task automatic test_start_ignored();
        kick(3);
        for (int c = 1; c <= 10; c++) begin
            if (obs() !== model(c, 3)) begin
                failures++;
                $display("FAIL ignore c%0d got=%h exp=%h", c, obs(), model(c, 3));
            end
            checks++;
            bus.start_i = (c == 2) || (c == 6) || (c == 7);
            bus.len_i   = c[0] ? 4'd9 : 4'd6;
            if (c >= 8) bus.start_i = 1'b0;
            step();
        end
        bus.start_i = 1'b0;
        bus.len_i   = '0;
    endtask

    task automatic test_len15_and_reset();
        kick(15);
        for (int c = 1; c <= 21; c++) begin
            if (obs() !== model(c, 15)) begin
                failures++;
                $display("FAIL len15 c%0d got=%h exp=%h", c, obs(), model(c, 15));
            end
            checks++;
            step();
        end
        kick(15);
        for (int c = 1; c <= 10; c++) begin
            if (obs() !== model(c, 15)) begin
                failures++;
                $display("FAIL len15_rst c%0d got=%h exp=%h", c, obs(), model(c, 15));
            end
            checks++;
            if (c == 10) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        for (int c = 11; c <= 30; c++) begin
            if (obs() !== exp_vec(0, 0)) begin
                failures++;
                $display("FAIL after_rst c%0d got=%h exp=%h", c, obs(), exp_vec(0, 0));
            end
            checks++;
            step();
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.len_i   = '0;
        bus.abort_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_len5();
        test_len0();
        test_abort();
        test_start_ignored();
        test_len15_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
